// File: rtl/flood_ctrl.sv
// Flood-It sequencer: absorbs the starting region, then recolours and grows the flood per move.
// Latency: 1 + passes*(size^2+1) + 1 cycles per move; RAM data is expected one cycle after RAM_ADDR.
// Backpressure: level requests held by the front end; armed gating stops a held move from being serviced twice.
module flood_ctrl #(
  parameter int MAX_SIZE = 26,
  parameter int COL_W    = 5
) (
  input  logic       MASTER_CLOCK,
  input  logic       RESET,
  input  logic       BEGIN_GAME,
  output logic       ACK_BEGIN_GAME,
  input  logic [4:0] final_SIZE,
  input  logic       COLOR_SEL_SIG,
  input  logic [2:0] COLOR_SELECTED,
  output logic       CURRENTLY_CHANGING_COLOR,
  input  logic [7:0] TRIES,
  input  logic [7:0] TOTAL_TRIES,
  output logic [9:0] RAM_ADDR,
  input  logic [2:0] RAM_RDATA,
  output logic       RAM_WE,
  output logic [2:0] RAM_WDATA,
  output logic       INITIALIZED,
  output logic       GAME_WON,
  output logic       GAME_LOST
);

  localparam int ROW_W = 10 - COL_W;

  typedef enum logic [2:0] {IDLE, INIT_RD, SWEEP, CHECK, WAIT, OVER} state_t;

  state_t state, state_nx;

  logic [MAX_SIZE-1:0][MAX_SIZE-1:0] bm;
  logic [4:0] size_q;
  logic [9:0] sq;
  logic [4:0] row, col;
  logic [4:0] p_row, p_col;
  logic       p_vld;
  logic [9:0] cyc;
  logic       pass0, wr_en, move_mode, changed, rd_phase, armed;
  logic [2:0] cur_color;
  logic [9:0] flood_cnt;

  logic begin_acc, accept, cell_fl, nbr_fl;
  logic write_now, absorb, issue, pass_end, more, init_fin;

  assign sq = 10'(size_q) * 10'(size_q);

  // ACK gating keeps a request that is still high during its own ACK cycle from re-triggering.
  assign begin_acc = BEGIN_GAME && !ACK_BEGIN_GAME;
  assign accept    = COLOR_SEL_SIG && armed;
  assign cell_fl   = bm[p_row][p_col];
  assign issue     = (state == SWEEP) && (cyc < sq);
  assign pass_end  = (state == SWEEP) && (cyc == sq);
  assign write_now = (state == SWEEP) && p_vld && cell_fl && pass0 && wr_en;
  assign absorb    = (state == SWEEP) && p_vld && !cell_fl && (RAM_RDATA == cur_color) && nbr_fl;
  assign more      = changed || absorb;
  assign init_fin  = pass_end && !more && !move_mode;

  // Neighbour test reads the live bitmap, so cells absorbed earlier in this pass count.
  always_comb begin
    nbr_fl = 1'b0;
    if (p_row != 5'd0)
      nbr_fl = nbr_fl | bm[p_row - 5'd1][p_col];
    if ((p_row + 5'd1) < size_q)
      nbr_fl = nbr_fl | bm[p_row + 5'd1][p_col];
    if (p_col != 5'd0)
      nbr_fl = nbr_fl | bm[p_row][p_col - 5'd1];
    if ((p_col + 5'd1) < size_q)
      nbr_fl = nbr_fl | bm[p_row][p_col + 5'd1];
  end

  always_ff @(posedge MASTER_CLOCK) begin
    if (RESET)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    RAM_ADDR  = '0;
    RAM_WE    = 1'b0;
    RAM_WDATA = '0;
    case (state)
      IDLE:    state_nx = IDLE;
      INIT_RD: if (rd_phase) state_nx = SWEEP;
      SWEEP:   if (pass_end && !more) state_nx = move_mode ? CHECK : WAIT;
      CHECK: begin
        if ((flood_cnt == sq) || (TRIES >= TOTAL_TRIES))
          state_nx = OVER;
        else
          state_nx = WAIT;
      end
      WAIT:    if (accept) state_nx = (COLOR_SELECTED == cur_color) ? CHECK : SWEEP;
      OVER:    state_nx = OVER;
      default: state_nx = IDLE;
    endcase
    if (begin_acc)
      state_nx = INIT_RD;
    if (issue)
      RAM_ADDR = {ROW_W'(row), COL_W'(col)};
    if (write_now) begin
      RAM_WE    = 1'b1;
      RAM_WDATA = cur_color;
    end
  end

  always_ff @(posedge MASTER_CLOCK) begin
    if (RESET) begin
      ACK_BEGIN_GAME           <= 1'b0;
      CURRENTLY_CHANGING_COLOR <= 1'b0;
      INITIALIZED              <= 1'b0;
      GAME_WON                 <= 1'b0;
      GAME_LOST                <= 1'b0;
      bm        <= '0;
      size_q    <= '0;
      row       <= '0;
      col       <= '0;
      p_row     <= '0;
      p_col     <= '0;
      p_vld     <= 1'b0;
      cyc       <= '0;
      pass0     <= 1'b0;
      wr_en     <= 1'b0;
      move_mode <= 1'b0;
      changed   <= 1'b0;
      rd_phase  <= 1'b0;
      armed     <= 1'b0;
      cur_color <= '0;
      flood_cnt <= '0;
    end else if (begin_acc) begin
      ACK_BEGIN_GAME           <= 1'b1;
      CURRENTLY_CHANGING_COLOR <= 1'b0;
      GAME_WON                 <= 1'b0;
      GAME_LOST                <= 1'b0;
      size_q    <= final_SIZE;
      bm        <= '0;
      bm[0][0]  <= 1'b1;
      flood_cnt <= 10'd1;
      rd_phase  <= 1'b0;
      p_vld     <= 1'b0;
      changed   <= 1'b0;
    end else begin
      ACK_BEGIN_GAME <= 1'b0;
      case (state)
        INIT_RD: begin
          rd_phase <= 1'b1;
          if (rd_phase) begin
            cur_color <= RAM_RDATA;
            row       <= '0;
            col       <= '0;
            cyc       <= '0;
            p_vld     <= 1'b0;
            changed   <= 1'b0;
            pass0     <= 1'b1;
            wr_en     <= 1'b0;
            move_mode <= 1'b0;
          end
        end
        SWEEP: begin
          cyc <= cyc + 10'd1;
          if (issue) begin
            p_vld <= 1'b1;
            p_row <= row;
            p_col <= col;
            if (col == size_q - 5'd1) begin
              col <= '0;
              row <= row + 5'd1;
            end else begin
              col <= col + 5'd1;
            end
          end else begin
            p_vld <= 1'b0;
          end
          if (absorb) begin
            bm[p_row][p_col] <= 1'b1;
            flood_cnt        <= flood_cnt + 10'd1;
            changed          <= 1'b1;
          end
          // Follow-up passes never write: pass 0 already recoloured every flooded cell.
          if (pass_end) begin
            if (more) begin
              row     <= '0;
              col     <= '0;
              cyc     <= '0;
              p_vld   <= 1'b0;
              changed <= 1'b0;
              pass0   <= 1'b0;
            end else if (!move_mode) begin
              INITIALIZED <= 1'b1;
            end
          end
        end
        CHECK: begin
          CURRENTLY_CHANGING_COLOR <= 1'b0;
          if (flood_cnt == sq)
            GAME_WON <= 1'b1;
          else if (TRIES >= TOTAL_TRIES)
            GAME_LOST <= 1'b1;
        end
        WAIT: begin
          if (!COLOR_SEL_SIG) begin
            armed <= 1'b1;
          end else if (armed) begin
            armed                    <= 1'b0;
            CURRENTLY_CHANGING_COLOR <= 1'b1;
            if (COLOR_SELECTED != cur_color) begin
              cur_color <= COLOR_SELECTED;
              row       <= '0;
              col       <= '0;
              cyc       <= '0;
              p_vld     <= 1'b0;
              changed   <= 1'b0;
              pass0     <= 1'b1;
              wr_en     <= 1'b1;
              move_mode <= 1'b1;
            end
          end
        end
        OVER: begin
          CURRENTLY_CHANGING_COLOR <= accept;
          if (!COLOR_SEL_SIG)
            armed <= 1'b1;
          else if (armed)
            armed <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_flood_ctrl.sv
// Scoreboard bench for flood_ctrl: stimulus queues expected events, a negedge monitor pops and compares.
// RAM model registers the address; reads and writes both act on the cell whose data is on RAM_RDATA.
module tb_flood_ctrl;

  localparam int EV_ACK  = 0;
  localparam int EV_WR   = 1;
  localparam int EV_ACC  = 2;
  localparam int EV_DONE = 3;
  localparam int EV_INIT = 4;

  logic       MASTER_CLOCK = 1'b0;
  logic       RESET = 1'b1;
  logic       BEGIN_GAME = 1'b0;
  logic       ACK_BEGIN_GAME;
  logic [4:0] final_SIZE = 5'd2;
  logic       COLOR_SEL_SIG = 1'b0;
  logic [2:0] COLOR_SELECTED = 3'd0;
  logic       CURRENTLY_CHANGING_COLOR;
  logic [7:0] TRIES = 8'd0;
  logic [7:0] TOTAL_TRIES = 8'd0;
  logic [9:0] RAM_ADDR;
  logic [2:0] RAM_RDATA;
  logic       RAM_WE;
  logic [2:0] RAM_WDATA;
  logic       INITIALIZED;
  logic       GAME_WON;
  logic       GAME_LOST;

  flood_ctrl dut (
    .MASTER_CLOCK(MASTER_CLOCK), .RESET(RESET),
    .BEGIN_GAME(BEGIN_GAME), .ACK_BEGIN_GAME(ACK_BEGIN_GAME), .final_SIZE(final_SIZE),
    .COLOR_SEL_SIG(COLOR_SEL_SIG), .COLOR_SELECTED(COLOR_SELECTED),
    .CURRENTLY_CHANGING_COLOR(CURRENTLY_CHANGING_COLOR),
    .TRIES(TRIES), .TOTAL_TRIES(TOTAL_TRIES),
    .RAM_ADDR(RAM_ADDR), .RAM_RDATA(RAM_RDATA), .RAM_WE(RAM_WE), .RAM_WDATA(RAM_WDATA),
    .INITIALIZED(INITIALIZED), .GAME_WON(GAME_WON), .GAME_LOST(GAME_LOST)
  );

  always #5 MASTER_CLOCK = ~MASTER_CLOCK;

  logic [2:0] mem [1024];
  logic [9:0] addr_q = '0;
  logic       fill_go = 1'b0;
  int         fill_pat = 0;

  function automatic logic [2:0] pat_color(input int p, input int a);
    logic [2:0] v;
    int r, c;
    r = a / 32;
    c = a % 32;
    v = 3'd7;
    if (p == 0) begin
      if (a == 0 || a == 32) v = 3'd1;
      else if (a == 1 || a == 33) v = 3'd2;
    end else if (p == 1) begin
      v = 3'((r + c) % 2);
    end else begin
      v = (r == 0) ? 3'd0 : 3'd5;
    end
    return v;
  endfunction

  always @(posedge MASTER_CLOCK) begin
    if (fill_go) begin
      for (int a = 0; a < 1024; a++) mem[a] <= pat_color(fill_pat, a);
    end else if (RAM_WE) begin
      mem[addr_q] <= RAM_WDATA;
    end
    addr_q <= RAM_ADDR;
  end
  assign RAM_RDATA = mem[addr_q];

  typedef struct {int kind; int a; int b; int c;} ev_t;
  ev_t exp_q[$];
  int n_chk = 0, n_fail = 0;
  int n_ack = 0, n_acc = 0, n_done = 0, n_init = 0, n_wr = 0;

  function automatic string kname(input int k);
    case (k)
      EV_ACK:  return "ack";
      EV_WR:   return "ram_write";
      EV_ACC:  return "move_accept";
      EV_DONE: return "move_done";
      default: return "init_done";
    endcase
  endfunction

  task automatic push(input int k, input int a, input int b, input int c);
    ev_t e;
    e.kind = k; e.a = a; e.b = b; e.c = c;
    exp_q.push_back(e);
  endtask

  task automatic see(input int k, input int a, input int b, input int c);
    ev_t e;
    n_chk++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_%s actual a=%0d b=%0d c=%0d required no event", kname(k), a, b, c);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.a != a || e.b != b || e.c != c) begin
        n_fail++;
        $display("FAIL event_%s actual %s a=%0d b=%0d c=%0d required %s a=%0d b=%0d c=%0d",
                 kname(e.kind), kname(k), a, b, c, kname(e.kind), e.a, e.b, e.c);
      end
    end
  endtask

  initial begin
    logic prev_ccc;
    prev_ccc = 1'b0;
    forever begin
      @(negedge MASTER_CLOCK);
      if (ACK_BEGIN_GAME) begin see(EV_ACK, 0, 0, 0); n_ack++; end
      if (RAM_WE) begin see(EV_WR, int'(addr_q), int'(RAM_WDATA), 0); n_wr++; end
      if (CURRENTLY_CHANGING_COLOR && !prev_ccc) begin see(EV_ACC, 0, 0, 0); n_acc++; end
      if (!CURRENTLY_CHANGING_COLOR && prev_ccc) begin
        see(EV_DONE, int'(GAME_WON), int'(GAME_LOST), int'(dut.flood_cnt));
        n_done++;
      end
      if (dut.init_fin) begin see(EV_INIT, int'(dut.flood_cnt), 0, 0); n_init++; end
      prev_ccc = CURRENTLY_CHANGING_COLOR;
    end
  end

  task automatic chk(input string nm, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  function automatic int cnt(input int which);
    case (which)
      EV_ACK:  return n_ack;
      EV_ACC:  return n_acc;
      EV_DONE: return n_done;
      default: return n_init;
    endcase
  endfunction

  task automatic wait_for(input int which, input int target, input int budget, input string nm);
    for (int i = 0; i < budget; i++) begin
      if (cnt(which) >= target) break;
      @(negedge MASTER_CLOCK);
    end
    n_chk++;
    if (cnt(which) < target) begin
      n_fail++;
      $display("FAIL timeout_%s actual=%0d required=%0d", nm, cnt(which), target);
    end
  endtask

  task automatic fill(input int p);
    @(negedge MASTER_CLOCK);
    fill_pat = p;
    fill_go  = 1'b1;
    @(negedge MASTER_CLOCK);
    fill_go  = 1'b0;
  endtask

  task automatic start_game(input logic [4:0] sz, input int init_cnt);
    int a0, i0;
    a0 = n_ack;
    i0 = n_init;
    push(EV_ACK, 0, 0, 0);
    push(EV_INIT, init_cnt, 0, 0);
    final_SIZE = sz;
    BEGIN_GAME = 1'b1;
    wait_for(EV_ACK, a0 + 1, 50, "ack");
    BEGIN_GAME = 1'b0;
    chk("flags_cleared", int'({GAME_WON, GAME_LOST}), 0);
    wait_for(EV_INIT, i0 + 1, 5000, "init");
    repeat (3) @(negedge MASTER_CLOCK);
    chk("initialized", int'(INITIALIZED), 1);
  endtask

  task automatic do_move(input logic [2:0] c, input logic [7:0] t, input logic [7:0] tt);
    int c0, d0;
    c0 = n_acc;
    d0 = n_done;
    COLOR_SELECTED = c;
    TRIES = t;
    TOTAL_TRIES = tt;
    COLOR_SEL_SIG = 1'b1;
    wait_for(EV_ACC, c0 + 1, 50, "move_accept");
    COLOR_SEL_SIG = 1'b0;
    wait_for(EV_DONE, d0 + 1, 5000, "move_done");
    repeat (3) @(negedge MASTER_CLOCK);
  endtask

  initial begin
    int acc0, found;

    // Reset with BEGIN_GAME held: reset must win.
    RESET = 1'b1;
    BEGIN_GAME = 1'b1;
    repeat (3) begin
      @(negedge MASTER_CLOCK);
      chk("ack_during_reset", int'(ACK_BEGIN_GAME), 0);
    end
    RESET = 1'b0;
    BEGIN_GAME = 1'b0;
    repeat (10) @(negedge MASTER_CLOCK);
    chk("rst_ack", int'(ACK_BEGIN_GAME), 0);
    chk("rst_busy", int'(CURRENTLY_CHANGING_COLOR), 0);
    chk("rst_addr", int'(RAM_ADDR), 0);
    chk("rst_we", int'(RAM_WE), 0);
    chk("rst_wdata", int'(RAM_WDATA), 0);
    chk("rst_init", int'(INITIALIZED), 0);
    chk("rst_won", int'(GAME_WON), 0);
    chk("rst_lost", int'(GAME_LOST), 0);
    chk("rst_no_writes", n_wr, 0);

    // 2x2 board: init absorbs (1,0); move to 2 fills the board and wins.
    fill(0);
    start_game(5'd2, 2);
    chk("init_no_writes", n_wr, 0);
    push(EV_ACC, 0, 0, 0);
    push(EV_WR, 0, 2, 0);
    push(EV_WR, 32, 2, 0);
    push(EV_DONE, 1, 0, 4);
    do_move(3'd2, 8'd1, 8'd1);
    chk("ram0_after_move", int'(mem[0]), 2);
    chk("ram32_after_move", int'(mem[32]), 2);
    chk("won_flag", int'(GAME_WON), 1);

    // 6x6 checkerboard: one move grows to 3 cells and runs out of tries.
    fill(1);
    start_game(5'd6, 1);
    push(EV_ACC, 0, 0, 0);
    push(EV_WR, 0, 1, 0);
    push(EV_DONE, 0, 1, 3);
    do_move(3'd1, 8'd3, 8'd3);
    chk("lost_flag", int'(GAME_LOST), 1);

    // Same-colour move held for 20 cycles: one acceptance, no sweep.
    start_game(5'd6, 3);
    acc0 = n_acc;
    push(EV_ACC, 0, 0, 0);
    push(EV_DONE, 0, 0, 3);
    COLOR_SELECTED = 3'd1;
    TRIES = 8'd0;
    TOTAL_TRIES = 8'd5;
    COLOR_SEL_SIG = 1'b1;
    repeat (20) @(negedge MASTER_CLOCK);
    COLOR_SEL_SIG = 1'b0;
    repeat (5) @(negedge MASTER_CLOCK);
    chk("single_accept", n_acc - acc0, 1);
    chk("same_color_busy_low", int'(CURRENTLY_CHANGING_COLOR), 0);

    // 26x26 board, top row flooded; abort the recolouring after ten writes.
    fill(2);
    start_game(5'd26, 26);
    push(EV_ACC, 0, 0, 0);
    for (int i = 0; i < 10; i++) push(EV_WR, i, 3, 0);
    COLOR_SELECTED = 3'd3;
    TRIES = 8'd0;
    TOTAL_TRIES = 8'd9;
    COLOR_SEL_SIG = 1'b1;
    wait_for(EV_ACC, acc0 + 2, 50, "big_accept");
    COLOR_SEL_SIG = 1'b0;
    found = 0;
    for (int i = 0; i < 300 && found == 0; i++) begin
      @(negedge MASTER_CLOCK);
      if (RAM_WE && addr_q == 10'd9) found = 1;
    end
    chk("abort_point_seen", found, 1);
    push(EV_ACK, 0, 0, 0);
    push(EV_DONE, 0, 0, 1);
    push(EV_INIT, 10, 0, 0);
    BEGIN_GAME = 1'b1;
    wait_for(EV_ACK, n_ack + 1, 50, "abort_ack");
    BEGIN_GAME = 1'b0;
    chk("abort_busy_low", int'(CURRENTLY_CHANGING_COLOR), 0);
    wait_for(EV_INIT, n_init + 1, 5000, "reinit");
    repeat (3) @(negedge MASTER_CLOCK);
    chk("abort_cell10_untouched", int'(mem[10]), 0);
    chk("abort_cell9_written", int'(mem[9]), 3);
    chk("reinit_flags", int'({GAME_WON, GAME_LOST}), 0);

    repeat (5) @(negedge MASTER_CLOCK);
    chk("expected_events_left", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
